ahb_arbiter: RTL and testbench

- Round-robin bus arbiter sharing the single AHB address/data path between NO_OF_MASTERS managers ahead of the decoder/mux/subordinate fabric.
- Samples per-master requests and locks, tracks fixed-length bursts from the shared HTRANS/HBURST, and re-arbitrates only at legal handover points.
- Drives one-hot grants, the current bus-owner index (which steers the master-side address/data mux), and HMASTLOCK.

---
 rtl/ahb_arbiter.sv | 117 +++++++++++
 tb/tb_ahb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: tracks fixed-length bursts from HTRANS/HBURST and
// re-grants the shared address/data path only at legal handover points.
module ahb_arbiter #(
    parameter int unsigned NO_OF_MASTERS   = 4,
    parameter int unsigned MASTER_ID_WIDTH = 2,
    parameter int unsigned DEFAULT_MASTER  = 0
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [NO_OF_MASTERS-1:0]   HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0]   HLOCK,
    input  logic [1:0]                 HTRANS,
    input  logic [2:0]                 HBURST,
    input  logic                       HREADY,
    output logic [NO_OF_MASTERS-1:0]   HGRANT,
    output logic [MASTER_ID_WIDTH-1:0] HMASTER,
    output logic                       HMASTLOCK
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    localparam logic [MASTER_ID_WIDTH-1:0] DefaultId    = MASTER_ID_WIDTH'(DEFAULT_MASTER);
    localparam logic [NO_OF_MASTERS-1:0]   DefaultGrant = NO_OF_MASTERS'(1) << DEFAULT_MASTER;

    logic [3:0]                 cnt_q, cnt_d;
    logic [NO_OF_MASTERS-1:0]   grant_q, grant_d;
    logic [MASTER_ID_WIDTH-1:0] master_q, master_d;
    logic                       mastlock_q, mastlock_d;

    logic                       lock_hold;
    logic                       arb_point;
    logic [MASTER_ID_WIDTH-1:0] winner;
    logic [MASTER_ID_WIDTH-1:0] cand;
    logic                       found;
    int unsigned                idx;

    // Remaining beats after the NONSEQ beat of a fixed-length burst.
    function automatic logic [3:0] burst_last(input logic [2:0] burst);
        logic [3:0] last;
        unique case (burst)
            3'b010, 3'b011: last = 4'd3;
            3'b100, 3'b101: last = 4'd7;
            3'b110, 3'b111: last = 4'd15;
            default:        last = 4'd0;
        endcase
        return last;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (HREADY) begin
            unique case (HTRANS)
                TransNonseq: cnt_d = burst_last(HBURST);
                TransSeq:    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                TransIdle:   cnt_d = 4'd0;
                TransBusy:   cnt_d = cnt_q;
                default:     cnt_d = cnt_q;
            endcase
        end
    end

    assign lock_hold = mastlock_q & HLOCK[master_q];
    assign arb_point = HREADY & (cnt_d == 4'd0) & (HTRANS != TransBusy) & ~lock_hold;

    // Search starts one past the owner; the owner itself is the last candidate.
    always_comb begin
        winner = DefaultId;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int unsigned i = 1; i <= NO_OF_MASTERS; i++) begin
            idx = 32'(master_q) + i;
            if (idx >= NO_OF_MASTERS) begin
                idx = idx - NO_OF_MASTERS;
            end
            cand = MASTER_ID_WIDTH'(idx);
            if (!found && HBUSREQ[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_d    = grant_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;
        if (arb_point) begin
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            master_d        = winner;
            mastlock_d      = HLOCK[winner] & HBUSREQ[winner];
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            cnt_q      <= 4'd0;
            grant_q    <= DefaultGrant;
            master_q   <= DefaultId;
            mastlock_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed handover scenarios plus randomized
// traffic, all checked every cycle against a behavioural ownership model.
module tb_ahb_arbiter;

    localparam int N   = 4;
    localparam int W   = 2;
    localparam int DEF = 0;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HLOCK;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic         HREADY;
    logic [N-1:0] HGRANT;
    logic [W-1:0] HMASTER;
    logic         HMASTLOCK;

    int total = 0;
    int bad   = 0;

    // Model state: who owns the bus, whether it is locked, beats still owed.
    int m_owner = DEF;
    bit m_lock  = 1'b0;
    int m_rem   = 0;
    bit chk_en  = 1'b0;
    int cyc     = 0;

    int lens[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    ahb_arbiter #(
        .NO_OF_MASTERS  (N),
        .MASTER_ID_WIDTH(W),
        .DEFAULT_MASTER (DEF)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    // Ownership rules applied to the inputs present at the coming edge.
    task automatic model_step();
        int  nrem;
        int  win;
        bit  found;
        bit  handover;
        if (!HRESETn) begin
            m_owner = DEF;
            m_lock  = 1'b0;
            m_rem   = 0;
            return;
        end
        if (!HREADY) return;
        case (HTRANS)
            2'b10:   nrem = lens[HBURST] - 1;
            2'b11:   nrem = (m_rem > 0) ? m_rem - 1 : 0;
            2'b00:   nrem = 0;
            default: nrem = m_rem;
        endcase
        handover = (nrem == 0) && (HTRANS != 2'b01) && !(m_lock && HLOCK[m_owner]);
        m_rem = nrem;
        if (handover) begin
            win   = DEF;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && HBUSREQ[(m_owner + k) % N]) begin
                    win   = (m_owner + k) % N;
                    found = 1'b1;
                end
            end
            m_owner = win;
            m_lock  = HLOCK[win] && HBUSREQ[win];
        end
    endtask

    // Advance one clock; on return the DUT has taken the edge and inputs may change.
    task automatic tick();
        @(negedge HCLK);
        #1;
        model_step();
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic rstn, input logic [N-1:0] req, input logic [N-1:0] lck,
                         input logic [1:0] trans, input logic [2:0] burst, input logic rdy);
        HRESETn = rstn;
        HBUSREQ = req;
        HLOCK   = lck;
        HTRANS  = trans;
        HBURST  = burst;
        HREADY  = rdy;
    endtask

    task automatic lit(input string name, input logic [N-1:0] gnt, input logic [W-1:0] mst,
                       input logic lck);
        total++;
        if (HGRANT !== gnt || HMASTER !== mst || HMASTLOCK !== lck) begin
            bad++;
            $display("FAIL %s: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                     name, HGRANT, HMASTER, HMASTLOCK, gnt, mst, lck);
        end
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            logic [N-1:0] eg;
            eg = N'(1) << m_owner;
            total++;
            if (HGRANT !== eg || HMASTER !== W'(m_owner) || HMASTLOCK !== m_lock
                || $countones(HGRANT) != 1 || int'(HMASTER) >= N) begin
                bad++;
                $display("FAIL model cycle %0d: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                         cyc, HGRANT, HMASTER, HMASTLOCK, eg, m_owner, m_lock);
            end
        end
    end

    initial begin
        drive(1'b0, 4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1);
        tick();
        chk_en = 1'b1;
        lit("reset", 4'b0001, 2'd0, 1'b0);

        // Round-robin rotation with SINGLE transfers.
        drive(1'b1, 4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1);
        tick(); lit("rot1", 4'b0010, 2'd1, 1'b0);
        tick(); lit("rot2", 4'b0100, 2'd2, 1'b0);
        tick(); lit("rot3", 4'b1000, 2'd3, 1'b0);
        tick(); lit("rot0", 4'b0001, 2'd0, 1'b0);

        // INCR4 by master 1 with master 2 waiting.
        drive(1'b1, 4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1);
        tick(); lit("own1", 4'b0010, 2'd1, 1'b0);
        drive(1'b1, 4'b0110, 4'b0000, 2'b10, 3'b011, 1'b1);
        tick(); lit("incr4_b1", 4'b0010, 2'd1, 1'b0);
        HTRANS = 2'b11;
        tick(); lit("incr4_b2", 4'b0010, 2'd1, 1'b0);
        tick(); lit("incr4_b3", 4'b0010, 2'd1, 1'b0);
        tick(); lit("incr4_end", 4'b0100, 2'd2, 1'b0);

        // Same INCR4, three wait states on beat 2.
        drive(1'b1, 4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1);
        tick(); lit("own1b", 4'b0010, 2'd1, 1'b0);
        drive(1'b1, 4'b0110, 4'b0000, 2'b10, 3'b011, 1'b1);
        tick();
        HTRANS = 2'b11;
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); lit("wait_hold", 4'b0010, 2'd1, 1'b0);
        end
        HREADY = 1'b1;
        tick(); lit("wait_b2", 4'b0010, 2'd1, 1'b0);
        tick(); lit("wait_b3", 4'b0010, 2'd1, 1'b0);
        tick(); lit("wait_end", 4'b0100, 2'd2, 1'b0);

        // Locked ownership by master 3, then release.
        drive(1'b1, 4'b1000, 4'b1000, 2'b00, 3'b000, 1'b1);
        tick(); lit("lock_get", 4'b1000, 2'd3, 1'b1);
        drive(1'b1, 4'b1111, 4'b1000, 2'b10, 3'b000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); lit("lock_hold", 4'b1000, 2'd3, 1'b1);
        end
        HLOCK = 4'b0000;
        tick(); lit("lock_rel", 4'b0001, 2'd0, 1'b0);

        // All requests withdrawn while master 2 owns the bus.
        drive(1'b1, 4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1);
        tick(); lit("own2", 4'b0100, 2'd2, 1'b0);
        HBUSREQ = 4'b0000;
        tick(); lit("default", 4'b0001, 2'd0, 1'b0);

        // Reset in the middle of an INCR8 held by master 1.
        drive(1'b1, 4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1);
        tick();
        drive(1'b1, 4'b1111, 4'b0000, 2'b10, 3'b101, 1'b1);
        tick(); lit("incr8_start", 4'b0010, 2'd1, 1'b0);
        drive(1'b0, 4'b1111, 4'b0000, 2'b11, 3'b101, 1'b1);
        tick(); lit("reset_mid", 4'b0001, 2'd0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) != 0), N'($urandom), N'($urandom),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0));
            // Bias toward sparse requests so default/single-owner cases appear.
            if ($urandom_range(0, 3) == 0) HBUSREQ = HBUSREQ & N'($urandom);
            tick();
        end

        @(negedge HCLK);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
